// File: rtl/fft_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_seq_ctrl_if
// Purpose  : Handshake and gen_addr control bundle for the FFT2048 sequencer.
//            The slave side is the sequencer. The master side is whoever
//            supplies start/in_valid/out_ready and observes the counters.
// Signals  : start, in_valid, out_ready        master -> slave
//            rd_cnt[10:0], wr_cnt[10:0]        slave -> master, gen_addr cnt
//            mode[1:0]                         slave -> master, gen_addr mode
//            rd_en, wr_en                      slave -> master, bank strobes
//            stage[2:0], busy, done            slave -> master, status
// Revision : 1.0  initial release
// ============================================================================
interface fft_seq_ctrl_if;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [10:0] rd_cnt;
  logic [10:0] wr_cnt;
  logic [1:0]  mode;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  stage;
  logic        busy;
  logic        done;

  modport master (
    output start, in_valid, out_ready,
    input  rd_cnt, wr_cnt, mode, rd_en, wr_en, stage, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output rd_cnt, wr_cnt, mode, rd_en, wr_en, stage, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_seq_ctrl
// Purpose  : Top-level sequencer of the FFT2048 core. Walks LOAD, five compute
//            stages with a drain gap after each, then UNLOAD, and drives the
//            cnt/mode inputs of gen_addr. The write-back counter is the read
//            counter delayed by the butterfly latency BF_LAT (1..15).
// Ports    : clk          clock, rising edge
//            rst_n        asynchronous active-low reset
//            bus (slave)  start/in_valid/out_ready in; rd_cnt, wr_cnt, mode,
//                         rd_en, wr_en, stage, busy, done out (all registered)
// Revision : 1.0  initial release
// ============================================================================
module fft_seq_ctrl #(
  parameter int BF_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_seq_ctrl_if.slave bus
);

  localparam logic [1:0]  c_mode_idle   = 2'b00;
  localparam logic [1:0]  c_mode_load   = 2'b11;
  localparam logic [1:0]  c_mode_calc   = 2'b01;
  localparam logic [1:0]  c_mode_unload = 2'b10;
  localparam logic [10:0] c_half_last   = 11'h3FF;
  localparam logic [10:0] c_calc_first  = 11'h400;
  localparam logic [3:0]  c_drain_init  = 4'(BF_LAT - 1);
  // One delay stage is the wr_cnt/wr_en output register itself.
  localparam int          DL_DEPTH      = (BF_LAT > 1) ? BF_LAT - 1 : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  logic [10:0] r_rd_cnt;
  logic [10:0] r_wr_cnt;
  logic [1:0]  r_mode;
  logic        r_rd_en;
  logic        r_wr_en;
  logic [2:0]  r_stage;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_drain;
  logic [10:0] r_dl_cnt [DL_DEPTH];
  logic        r_dl_vld [DL_DEPTH];

  logic [10:0] w_rd_inc;
  logic [10:0] w_tail_cnt;
  logic        w_tail_vld;

  // ST4 ends at 0x7FF and ST5 restarts at 0x000.
  assign w_rd_inc = (r_rd_cnt == 11'h7FF) ? 11'h000 : r_rd_cnt + 11'd1;

  generate
    if (BF_LAT == 1) begin : g_lat_one
      assign w_tail_cnt = r_rd_cnt;
      assign w_tail_vld = r_rd_en;
    end else begin : g_lat_multi
      assign w_tail_cnt = r_dl_cnt[DL_DEPTH-1];
      assign w_tail_vld = r_dl_vld[DL_DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_mode   <= c_mode_idle;
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_stage  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_drain  <= '0;
      for (int i = 0; i < DL_DEPTH; i++) begin
        r_dl_cnt[i] <= '0;
        r_dl_vld[i] <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
      // The read/write-back pipe only moves while the butterflies are active.
      if (r_state == S_CALC || r_state == S_DRAIN) begin
        r_dl_cnt[0] <= r_rd_cnt;
        r_dl_vld[0] <= r_rd_en;
        for (int i = 1; i < DL_DEPTH; i++) begin
          r_dl_cnt[i] <= r_dl_cnt[i-1];
          r_dl_vld[i] <= r_dl_vld[i-1];
        end
        r_wr_cnt <= w_tail_cnt;
        r_wr_en  <= w_tail_vld;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_LOAD;
            r_mode   <= c_mode_load;
            r_busy   <= 1'b1;
            r_rd_cnt <= '0;
            r_wr_en  <= 1'b0;
            // Stale entries from an earlier transform must never be written back.
            for (int i = 0; i < DL_DEPTH; i++) begin
              r_dl_cnt[i] <= '0;
              r_dl_vld[i] <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          r_wr_en  <= bus.in_valid;
          r_wr_cnt <= r_rd_cnt;
          if (bus.in_valid) begin
            if (r_rd_cnt == c_half_last) begin
              r_state  <= S_CALC;
              r_mode   <= c_mode_calc;
              r_rd_en  <= 1'b1;
              r_stage  <= 3'd1;
              r_rd_cnt <= c_calc_first;
            end else begin
              r_rd_cnt <= r_rd_cnt + 11'd1;
            end
          end
        end
        S_CALC: begin
          r_rd_cnt <= w_rd_inc;
          if (r_rd_cnt[7:0] == 8'hFF) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_drain <= c_drain_init;
          end
        end
        S_DRAIN: begin
          if (r_drain == 4'd0) begin
            r_rd_en <= 1'b1;
            if (r_stage == 3'd5) begin
              r_state  <= S_UNLOAD;
              r_mode   <= c_mode_unload;
              r_stage  <= '0;
              r_rd_cnt <= '0;
              r_wr_en  <= 1'b0;
            end else begin
              r_state <= S_CALC;
              r_stage <= r_stage + 3'd1;
            end
          end else begin
            r_drain <= r_drain - 4'd1;
          end
        end
        S_UNLOAD: begin
          if (bus.out_ready) begin
            if (r_rd_cnt == c_half_last) begin
              r_state  <= S_DONE;
              r_mode   <= c_mode_idle;
              r_rd_en  <= 1'b0;
              r_rd_cnt <= '0;
              r_done   <= 1'b1;
            end else begin
              r_rd_cnt <= r_rd_cnt + 11'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_cnt = r_rd_cnt;
  assign bus.wr_cnt = r_wr_cnt;
  assign bus.mode   = r_mode;
  assign bus.rd_en  = r_rd_en;
  assign bus.wr_en  = r_wr_en;
  assign bus.stage  = r_stage;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_seq_ctrl
// Purpose  : Self-checking bench for fft_seq_ctrl. A phase-level model predicts
//            every output each cycle; CALC/DRAIN is a fixed read schedule and
//            write-back is that schedule shifted by BF_LAT.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_seq_ctrl;

  localparam int BF_LAT    = 4;
  localparam int SLOT      = 256 + BF_LAT;
  localparam int SCHED_LEN = 5 * SLOT;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SCHED = 2, P_UNLOAD = 3, P_DONE = 4;

  logic clk;
  logic rst_n;
  fft_seq_ctrl_if bus ();

  fft_seq_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase = P_IDLE;
  int m_n     = 0;
  int m_t     = 0;
  bit m_lwr   = 1'b0;

  logic [10:0] obs_rd, obs_wc;
  logic [2:0]  obs_stage;
  logic        obs_rden, obs_wren, obs_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sched_rd(input int t);
    return (t % SLOT) < 256;
  endfunction

  // Drain cycles already show the next stage's first address.
  function automatic logic [10:0] sched_cnt(input int t);
    int s;
    int off;
    s   = t / SLOT;
    off = t % SLOT;
    if (off > 256) off = 256;
    return 11'((1024 + 256 * s + off) % 2048);
  endfunction

  task automatic compare_model();
    logic [1:0]  e_mode;
    logic [10:0] e_rd, e_wc;
    logic        e_rden, e_wren, e_busy, e_done;
    logic [2:0]  e_stage;
    e_mode = 2'b00; e_rd = '0; e_wc = '0; e_rden = 1'b0; e_wren = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_stage = '0;
    case (m_phase)
      P_LOAD: begin
        e_mode = 2'b11; e_busy = 1'b1; e_rd = 11'(m_n);
        e_wren = m_lwr; e_wc = 11'(m_n - 1);
      end
      P_SCHED: begin
        e_mode = 2'b01; e_busy = 1'b1;
        e_stage = 3'(m_t / SLOT + 1);
        e_rd = sched_cnt(m_t);
        e_rden = sched_rd(m_t);
        if (m_t == 0) begin
          e_wren = 1'b1; e_wc = 11'h3FF;
        end else if (m_t >= BF_LAT && sched_rd(m_t - BF_LAT)) begin
          e_wren = 1'b1; e_wc = sched_cnt(m_t - BF_LAT);
        end
      end
      P_UNLOAD: begin
        e_mode = 2'b10; e_busy = 1'b1; e_rden = 1'b1; e_rd = 11'(m_n);
      end
      P_DONE: begin
        e_busy = 1'b1; e_done = 1'b1;
      end
      default: ;
    endcase
    chk("mode",   bus.mode,   e_mode);
    chk("rd_cnt", bus.rd_cnt, e_rd);
    chk("rd_en",  bus.rd_en,  e_rden);
    chk("wr_en",  bus.wr_en,  e_wren);
    chk("stage",  bus.stage,  e_stage);
    chk("busy",   bus.busy,   e_busy);
    chk("done",   bus.done,   e_done);
    if (e_wren) chk("wr_cnt", bus.wr_cnt, e_wc);
  endtask

  task automatic step_model(input bit st, input bit iv, input bit ordy);
    case (m_phase)
      P_IDLE: if (st) begin m_phase = P_LOAD; m_n = 0; m_lwr = 1'b0; end
      P_LOAD: begin
        m_lwr = iv;
        if (iv) begin
          if (m_n == 1023) begin m_phase = P_SCHED; m_t = 0; end
          else m_n++;
        end
      end
      P_SCHED: begin
        m_t++;
        if (m_t == SCHED_LEN) begin m_phase = P_UNLOAD; m_n = 0; end
      end
      P_UNLOAD: if (ordy) begin
        if (m_n == 1023) m_phase = P_DONE;
        else m_n++;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  // One clock: check the current cycle, then drive inputs sampled at its end.
  task automatic cyc(input bit st, input bit iv, input bit ordy);
    @(negedge clk);
    compare_model();
    obs_rd = bus.rd_cnt; obs_wc = bus.wr_cnt; obs_stage = bus.stage;
    obs_rden = bus.rd_en; obs_wren = bus.wr_en; obs_done = bus.done;
    bus.start = st; bus.in_valid = iv; bus.out_ready = ordy;
    step_model(st, iv, ordy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_cnt"}, bus.rd_cnt, 0);
    chk({tag, "_wr_cnt"}, bus.wr_cnt, 0);
    chk({tag, "_mode"},   bus.mode,   0);
    chk({tag, "_rd_en"},  bus.rd_en,  0);
    chk({tag, "_wr_en"},  bus.wr_en,  0);
    chk({tag, "_stage"},  bus.stage,  0);
    chk({tag, "_busy"},   bus.busy,   0);
    chk({tag, "_done"},   bus.done,   0);
  endtask

  // Random full run; returns once done is seen or the budget runs out.
  task automatic random_run(input string tag, input bit with_stalls);
    bit iv, ordy, st, hold_now;
    int holds;
    int guard;
    bit ivs [4];
    int exp_seq [5];
    ivs = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_seq = '{0, 1, 1, 1, 2};
    holds = 0;
    cyc(1'b1, 1'b1, 1'b1);
    if (with_stalls) begin
      for (int i = 0; i < 5; i++) begin
        iv = (i < 4) ? ivs[i] : 1'b1;
        cyc(1'b0, iv, 1'b1);
        chk("load_stall", obs_rd, 32'(exp_seq[i]));
      end
    end
    guard = 0;
    obs_done = 1'b0;
    while (guard < 20000 && !obs_done) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      st   = ($urandom_range(0, 7) == 0);
      hold_now = 1'b0;
      if (with_stalls && m_phase == P_UNLOAD && m_n == 32'h200 && holds < 5) begin
        ordy = 1'b0; hold_now = 1'b1; holds++;
      end
      cyc(st, iv, ordy);
      if (hold_now) chk("unload_hold", obs_rd, 32'h200);
      guard++;
    end
    chk({tag, "_done_seen"}, obs_done, 1);
    if (with_stalls) chk("unload_hold_cnt", holds, 5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int done_cnt;
    bit st;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    m_phase = P_IDLE;

    // start low: remains idle.
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    // Clean full run with start poked during CALC and DONE.
    cyc(1'b1, 1'b1, 1'b1);
    cycles = 1;
    done_cnt = 0;
    obs_done = 1'b0;
    while (cycles < 5000 && !obs_done) begin
      st = (m_phase == P_DONE) || (m_phase == P_SCHED && m_t == 300);
      cyc(st, 1'b1, 1'b1);
      cycles++;
      if (obs_done) done_cnt++;
      if (cycles == 1026) begin
        chk("first_read_cnt", obs_rd, 32'h400);
        chk("first_read_en", obs_rden, 1);
        chk("first_stage", obs_stage, 1);
      end
      if (cycles == 1026 + BF_LAT) begin
        chk("first_wb_en", obs_wren, 1);
        chk("first_wb_cnt", obs_wc, 32'h400);
      end
      if (cycles == 1025 + SCHED_LEN) begin
        chk("last_wb_en", obs_wren, 1);
        chk("last_wb_cnt", obs_wc, 32'h0FF);
        chk("last_drain_rden", obs_rden, 0);
      end
    end
    chk("run_len", cycles, 1 + 1024 + 1300 + 1024 + 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (obs_done) done_cnt++;
    end
    chk("done_pulses", done_cnt, 1);

    // Randomized handshakes with directed LOAD/UNLOAD stalls.
    random_run("stall_run", 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Abort in stage 3.
    cyc(1'b1, 1'b1, 1'b1);
    cycles = 0;
    while (cycles < 4000 && !(m_phase == P_SCHED && m_t == 2 * SLOT + 20)) begin
      cyc(1'b0, 1'b1, 1'b1);
      cycles++;
    end
    @(negedge clk);
    chk("pre_abort_stage", bus.stage, 3);
    chk("pre_abort_rd_cnt", bus.rd_cnt, 32'h614);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_phase = P_IDLE;

    // Clean run after abort; model expects no stale write-back.
    random_run("post_abort", 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
